// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak unpadder.
// Pad byte values follow the pad10*1 scheme with big-endian byte order.
package keccak_pkg;

    localparam int RATE_BYTES = 72;
    localparam int WORD_BYTES = 8;

    localparam logic [7:0] PAD_FIRST = 8'h01;
    localparam logic [7:0] PAD_LAST  = 8'h80;
    localparam logic [7:0] PAD_BOTH  = 8'h81;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/keccak_pad_scan.sv
// Combinational pad10*1 scanner: finds message length of a final block.
// err is set when the tail does not form a legal pad.
module keccak_pad_scan
    import keccak_pkg::*;
#(
    parameter int RATE_BITS = 576
) (
    input  logic [RATE_BITS-1:0] block,
    output logic [6:0]           len,
    output logic                 err
);

    localparam int RB = RATE_BITS / 8;

    logic [7:0] tail;
    logic       nz_any;
    logic [6:0] nz_idx;
    logic [7:0] nz_val;

    always_comb begin
        tail   = block[7:0];
        nz_any = 1'b0;
        nz_idx = '0;
        nz_val = '0;
        // Highest-index nonzero byte before the tail must be the 0x01 marker
        for (int j = 0; j < RB - 1; j++) begin
            if (block[RATE_BITS-1-8*j -: 8] != 8'h00) begin
                nz_any = 1'b1;
                nz_idx = 7'(j);
                nz_val = block[RATE_BITS-1-8*j -: 8];
            end
        end
        len = '0;
        err = 1'b1;
        if (tail == PAD_BOTH) begin
            len = 7'(RB - 1);
            err = 1'b0;
        end else if (tail == PAD_LAST && nz_any && nz_val == PAD_FIRST) begin
            len = nz_idx;
            err = 1'b0;
        end
    end

endmodule

// File: rtl/keccak_unpadder.sv
// Receive-side pad10*1 stripper: takes padded rate blocks and streams
// the message back out as words with per-word valid byte counts.
module keccak_unpadder
    import keccak_pkg::*;
#(
    parameter int RATE_BITS = 576,
    parameter int WORD_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RATE_BITS-1:0] in_block,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [WORD_BITS-1:0] out_word,
    output logic [3:0]           out_bytes,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 pad_err
);

    localparam int RB = RATE_BITS / 8;
    localparam int WB = WORD_BITS / 8;
    localparam int NW = RATE_BITS / WORD_BITS;

    state_t               state;
    state_t               state_n;
    logic [RATE_BITS-1:0] blk;
    logic                 blk_last;
    logic [6:0]           len;
    logic [3:0]           k;
    logic [6:0]           scan_len;
    logic                 scan_err;
    logic [3:0]           last_k;
    logic [6:0]           len_m1;
    logic [6:0]           rem;
    logic [3:0]           nbytes;
    logic [WORD_BITS-1:0] raw;
    logic                 emit;

    keccak_pad_scan #(
        .RATE_BITS (RATE_BITS)
    ) u_scan (
        .block (blk),
        .len   (scan_len),
        .err   (scan_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pad_err = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) state_n = CHECK;
            end
            CHECK: begin
                if (blk_last && scan_err) begin
                    pad_err = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (out_ready && k == last_k) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and the first cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk      <= '0;
            blk_last <= 1'b0;
            len      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_n == IDLE);
            if (state == IDLE && in_valid && in_ready) begin
                blk      <= in_block;
                blk_last <= in_last;
            end
            if (state == CHECK) begin
                len <= blk_last ? scan_len : 7'(RB);
                k   <= '0;
            end else if (state == EMIT && out_ready) begin
                k <= k + 4'd1;
            end
        end
    end

    assign emit   = (state == EMIT);
    assign len_m1 = len - 7'd1;
    assign last_k = (len == '0) ? '0 : 4'(len_m1 / 7'(WB));
    assign rem    = len - 7'(32'(k) * WB);
    assign nbytes = (rem >= 7'(WB)) ? 4'(WB) : rem[3:0];

    always_comb begin
        raw = '0;
        for (int i = 0; i < NW; i++) begin
            if (k == 4'(i)) raw = blk[RATE_BITS-1-WORD_BITS*i -: WORD_BITS];
        end
    end

    always_comb begin
        out_word  = '0;
        out_bytes = '0;
        out_last  = 1'b0;
        out_valid = emit;
        if (emit) begin
            out_bytes = nbytes;
            out_last  = blk_last && (k == last_k);
            for (int i = 0; i < WB; i++) begin
                if (4'(i) < nbytes)
                    out_word[WORD_BITS-1-8*i -: 8] = raw[WORD_BITS-1-8*i -: 8];
            end
        end
    end

endmodule

// File: tb/tb_keccak_unpadder.sv
// Bench for keccak_unpadder: directed pad cases plus random blocks
// checked against a byte-level reference model.
module tb_keccak_unpadder;

    localparam int R = 72;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [575:0] in_block = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [63:0]  out_word;
    logic [3:0]   out_bytes;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         pad_err;

    always #5 clk = ~clk;

    keccak_unpadder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_block  (in_block),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pad_err   (pad_err)
    );

    logic [7:0]  b [R];
    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] ew [$];
    int          eb [$];
    bit          el [$];
    bit          eerr;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Message length from the pad rules, then slice into 8-byte words
    task automatic model(input bit last);
        int L;
        int n;
        logic [63:0] w;
        L = 0;
        eerr = 1'b0;
        ew.delete();
        eb.delete();
        el.delete();
        if (!last) begin
            L = R;
        end else if (b[R-1] == 8'h81) begin
            L = R - 1;
        end else begin
            int j = R - 2;
            while (j >= 0 && b[j] == 8'h00) j--;
            if (b[R-1] == 8'h80 && j >= 0 && b[j] == 8'h01) L = j;
            else eerr = 1'b1;
        end
        if (eerr) return;
        n = (L == 0) ? 1 : (L + 7) / 8;
        for (int wi = 0; wi < n; wi++) begin
            w = '0;
            for (int i = 0; i < 8; i++)
                if (8 * wi + i < L) w[63-8*i -: 8] = b[8*wi+i];
            ew.push_back(w);
            eb.push_back((L - 8 * wi > 8) ? 8 : L - 8 * wi);
            el.push_back(last && wi == n - 1);
        end
    endtask

    task automatic run(input bit last, input int stall_w, input int abort_w);
        int w;
        int cyc;
        int stall;
        logic [575:0] blkv;
        model(last);
        for (int i = 0; i < R; i++) blkv[575-8*i -: 8] = b[i];
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_wait", in_ready, 1);
        in_block = blkv;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_pad_err", pad_err, eerr);
        check("t1_out_valid", out_valid, 0);
        check("t1_in_ready", in_ready, 0);
        if (eerr) begin
            @(negedge clk);
            check("err_in_ready", in_ready, 1);
            check("err_out_valid", out_valid, 0);
            check("err_pad_err_clear", pad_err, 0);
            return;
        end
        @(negedge clk);
        w = 0;
        cyc = 0;
        stall = 0;
        while (w < ew.size() && cyc < 300) begin
            check("out_valid", out_valid, 1);
            check("out_word", out_word, ew[w]);
            check("out_bytes", out_bytes, eb[w]);
            check("out_last", out_last, el[w]);
            if (w == abort_w) begin
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_out_word", out_word, 0);
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("post_rst_in_ready", in_ready, 1);
                check("post_rst_out_valid", out_valid, 0);
                return;
            end
            if (w == stall_w && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(3) != 0);
            end
            @(posedge clk);
            if (out_ready) w++;
            @(negedge clk);
            cyc++;
        end
        check("word_count", w, ew.size());
        out_ready = 1'b0;
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);
    endtask

    task automatic fill_abc(input logic [7:0] tail);
        for (int i = 0; i < R; i++) b[i] = 8'h00;
        b[0] = 8'h61;
        b[1] = 8'h62;
        b[2] = 8'h63;
        b[3] = 8'h01;
        b[R-1] = tail;
    endtask

    initial begin
        int L;
        bit last;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_bytes", out_bytes, 0);
        check("rst_out_word", out_word, 0);
        check("rst_pad_err", pad_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < R; i++) b[i] = 8'(i);
        run(1'b0, -1, -1);

        fill_abc(8'h80);
        run(1'b1, -1, -1);

        for (int i = 0; i < R; i++) b[i] = 8'(i);
        b[R-1] = 8'h81;
        run(1'b1, -1, -1);

        for (int i = 0; i < R; i++) b[i] = 8'h00;
        b[0] = 8'h01;
        b[R-1] = 8'h80;
        run(1'b1, -1, -1);

        fill_abc(8'h00);
        run(1'b1, -1, -1);

        fill_abc(8'h80);
        b[10] = 8'h05;
        run(1'b1, -1, -1);

        for (int i = 0; i < R; i++) b[i] = 8'(i);
        run(1'b0, 3, -1);
        run(1'b0, -1, 3);

        fill_abc(8'h80);
        run(1'b1, -1, -1);

        for (int t = 0; t < 40; t++) begin
            last = 1'($urandom_range(1));
            for (int i = 0; i < R; i++) b[i] = 8'($urandom);
            if (last) begin
                L = $urandom_range(R - 1);
                if (L == R - 1) begin
                    b[R-1] = 8'h81;
                end else begin
                    b[L] = 8'h01;
                    for (int i = L + 1; i < R - 1; i++) b[i] = 8'h00;
                    b[R-1] = 8'h80;
                end
                if ($urandom_range(4) == 0)
                    b[$urandom_range(R - 1, L)] ^= 8'(1 << $urandom_range(7));
            end
            run(last, $urandom_range(9), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
